// File: rtl/gmii_rx_capture_if.sv
// -----------------------------------------------------------------------------
// gmii_rx_capture_if
// Bundle of the GMII receive inputs and the frame-buffer read side of
// gmii_rx_capture.
//   master : stimulus/consumer side. Drives rx_dv, rx_er, rx_data, rd_addr
//            and pop. Observes the frame status, rd_data and the counters.
//   slave  : capture block side (the direction of each signal is reversed).
// SLOT_AW must match the SLOT_AW of the gmii_rx_capture it connects to.
// -----------------------------------------------------------------------------
interface gmii_rx_capture_if #(
   parameter int SLOT_AW = 11
);
   logic               rx_dv;
   logic               rx_er;
   logic [7:0]         rx_data;
   logic               frame_avail;
   logic [SLOT_AW:0]   frame_len;
   logic               frame_err;
   logic [SLOT_AW-1:0] rd_addr;
   logic [7:0]         rd_data;
   logic               pop;
   logic [15:0]        frame_cnt;
   logic [15:0]        drop_cnt;
   logic               busy;

   modport master (
      output rx_dv, rx_er, rx_data, rd_addr, pop,
      input  frame_avail, frame_len, frame_err, rd_data, frame_cnt, drop_cnt, busy
   );

   modport slave (
      input  rx_dv, rx_er, rx_data, rd_addr, pop,
      output frame_avail, frame_len, frame_err, rd_data, frame_cnt, drop_cnt, busy
   );
endinterface

// File: rtl/gmii_rx_capture.sv
// -----------------------------------------------------------------------------
// gmii_rx_capture
// Captures GMII receive frames into a ring of 2^SLOTS_LOG2 slots, each holding
// 2^SLOT_AW bytes. The preamble and SFD are stripped when STRIP_PRE=1. A
// completed frame is committed to the ring. The consumer reads the head slot
// through rd_addr/rd_data, which has one cycle of latency, and releases the
// slot with pop.
// Ports:
//   i_clk : single clock. The GMII inputs are already in this domain.
//   i_rst : synchronous active-high reset.
//   bus   : gmii_rx_capture_if.slave. It carries the rx inputs, the
//           head-frame status, the read port, pop, the counters and busy.
// -----------------------------------------------------------------------------
module gmii_rx_capture #(
   parameter int SLOT_AW    = 11,
   parameter int SLOTS_LOG2 = 2,
   parameter int STRIP_PRE  = 1
) (
   input  logic               i_clk,
   input  logic               i_rst,
   gmii_rx_capture_if.slave   bus
);
   localparam int SLOT_BYTES = 1 << SLOT_AW;
   localparam int SLOTS      = 1 << SLOTS_LOG2;
   localparam logic [SLOTS_LOG2:0] OCC_FULL = (SLOTS_LOG2 + 1)'(SLOTS);

   typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_DATA, ST_DROP} state_t;

   state_t                r_state, w_state_nxt;
   logic                  r_armed;              // rx_dv seen low since reset
   logic [SLOTS_LOG2-1:0] r_wr_ptr, r_hd_ptr;
   logic [SLOTS_LOG2:0]   r_occ;
   logic [SLOT_AW:0]      r_len;
   logic                  r_err;                // rx_er seen or frame truncated
   logic [15:0]           r_frame_cnt, r_drop_cnt;
   logic [7:0]            r_rd_data;

   logic [7:0]            r_mem      [SLOTS*SLOT_BYTES];
   logic [SLOT_AW:0]      r_slot_len [SLOTS];
   logic                  r_slot_err [SLOTS];

   logic                  w_full, w_avail, w_pop_ok;
   logic                  w_wr_en, w_start, w_commit, w_drop;
   logic [SLOT_AW-1:0]    w_wr_off;

   // Full is judged on the registered occupancy, so a pop in the same cycle
   // cannot make room for the frame that is deciding now.
   assign w_full   = (r_occ == OCC_FULL);
   assign w_avail  = (r_occ != '0);
   assign w_pop_ok = bus.pop & w_avail;
   assign w_wr_off = w_start ? '0 : r_len[SLOT_AW-1:0];

   // NOTE: sequential state uses non-blocking (<=) assignments only, so every
   // flop samples values from before the edge, whatever order the blocks run in.
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // NOTE: each output of this block gets a default first. Without the
   // defaults, a branch that does not assign a signal would infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_wr_en     = 1'b0;
      w_start     = 1'b0;
      w_commit    = 1'b0;
      w_drop      = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (bus.rx_dv && r_armed) begin
               if (STRIP_PRE != 0) begin
                  w_state_nxt = ST_PRE;
               end else if (w_full) begin
                  w_state_nxt = ST_DROP;
                  w_drop      = 1'b1;
               end else begin
                  w_state_nxt = ST_DATA;
                  w_start     = 1'b1;
                  w_wr_en     = 1'b1;    // first byte lands at offset 0
               end
            end
         end
         ST_PRE: begin
            if (!bus.rx_dv) begin
               w_state_nxt = ST_IDLE;
            end else if (bus.rx_data == 8'hD5) begin
               if (w_full) begin
                  w_state_nxt = ST_DROP;
                  w_drop      = 1'b1;
               end else begin
                  w_state_nxt = ST_DATA;
                  w_start     = 1'b1;
               end
            end else if (bus.rx_data != 8'h55) begin
               w_state_nxt = ST_DROP;
               w_drop      = 1'b1;
            end
         end
         ST_DATA: begin
            if (bus.rx_dv) begin
               // len saturates at SLOT_BYTES. Its top bit marks a full slot.
               w_wr_en = ~r_len[SLOT_AW];
            end else begin
               w_state_nxt = ST_IDLE;
               w_commit    = (r_len != '0);
            end
         end
         ST_DROP: begin
            if (!bus.rx_dv) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_armed     <= 1'b0;
         r_wr_ptr    <= '0;
         r_hd_ptr    <= '0;
         r_occ       <= '0;
         r_len       <= '0;
         r_err       <= 1'b0;
         r_frame_cnt <= '0;
         r_drop_cnt  <= '0;
         r_rd_data   <= '0;
      end else begin
         if (!bus.rx_dv) r_armed <= 1'b1;

         if (w_start) begin
            r_len <= {{SLOT_AW{1'b0}}, w_wr_en};
            r_err <= w_wr_en & bus.rx_er;
         end else if (r_state == ST_DATA && bus.rx_dv) begin
            if (w_wr_en) r_len <= r_len + (SLOT_AW + 1)'(1);
            else         r_err <= 1'b1;             // truncated
            if (bus.rx_er) r_err <= 1'b1;
         end

         if (w_commit) begin
            r_wr_ptr    <= r_wr_ptr + SLOTS_LOG2'(1);
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
         if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
         if (w_pop_ok) r_hd_ptr <= r_hd_ptr + SLOTS_LOG2'(1);

         case ({w_commit, w_pop_ok})
            2'b10:   r_occ <= r_occ + (SLOTS_LOG2 + 1)'(1);
            2'b01:   r_occ <= r_occ - (SLOTS_LOG2 + 1)'(1);
            default: r_occ <= r_occ;
         endcase

         r_rd_data <= r_mem[{r_hd_ptr, bus.rd_addr}];
      end
   end

   // NOTE: the storage arrays have no reset. Every slot is written before it
   // is committed, and frame_len/frame_err are masked while the ring is empty,
   // so stale contents are never visible.
   always_ff @(posedge i_clk) begin
      if (w_wr_en) r_mem[{r_wr_ptr, w_wr_off}] <= bus.rx_data;
      if (w_commit) begin
         r_slot_len[r_wr_ptr] <= r_len;
         r_slot_err[r_wr_ptr] <= r_err | bus.rx_er;
      end
   end

   assign bus.frame_avail = w_avail;
   assign bus.frame_len   = w_avail ? r_slot_len[r_hd_ptr] : '0;
   assign bus.frame_err   = w_avail & r_slot_err[r_hd_ptr];
   assign bus.rd_data     = r_rd_data;
   assign bus.frame_cnt   = r_frame_cnt;
   assign bus.drop_cnt    = r_drop_cnt;
   assign bus.busy        = (r_state != ST_IDLE);
endmodule

// File: tb/tb_gmii_rx_capture.sv
// -----------------------------------------------------------------------------
// tb_gmii_rx_capture
// Directed bench for gmii_rx_capture. One instance has the preamble stripped
// and the other stores every byte. A table of single-frame cases is applied
// in a loop. Hand-written sequences cover the multi-cycle corner cases.
// -----------------------------------------------------------------------------
module tb_gmii_rx_capture;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   gmii_rx_capture_if #(.SLOT_AW(11)) bus ();
   gmii_rx_capture_if #(.SLOT_AW(11)) bus_np ();

   gmii_rx_capture #(.SLOT_AW(11), .SLOTS_LOG2(2), .STRIP_PRE(1)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   gmii_rx_capture #(.SLOT_AW(11), .SLOTS_LOG2(2), .STRIP_PRE(0)) dut_np (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus_np)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int exp_fc = 0;
   int exp_dc = 0;

   typedef struct {
      int         n_pay;
      int         er_idx;     // payload index carrying rx_er, -1 for none
      logic [7:0] base;
      int         exp_len;
      logic       exp_err;
      int         rd_addr;
      logic [7:0] exp_rd;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Payload byte i of a frame. The pattern does not repeat every 256 bytes,
   // so a wrapped write would show up as a wrong value.
   function automatic logic [7:0] pat(input logic [7:0] base, input int i);
      logic [7:0] lo, hi;
      lo = 8'(i);
      hi = 8'(i >> 8);
      return base + lo + hi * 8'd7;
   endfunction

   task automatic drive(input logic dv, input logic er, input logic [7:0] d);
      bus.rx_dv   = dv;
      bus.rx_er   = er;
      bus.rx_data = d;
      tick();
   endtask

   // Sends 7x 0x55, 0xD5, the payload, then one rx_dv-low cycle, which is the
   // commit edge. pop_last asserts pop in that same cycle.
   task automatic send_frame(input int n_pay, input logic [7:0] base, input int er_idx,
                             input logic pop_last);
      for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
      drive(1'b1, 1'b0, 8'hD5);
      for (int i = 0; i < n_pay; i++) drive(1'b1, 1'(i == er_idx), pat(base, i));
      bus.pop = pop_last;
      drive(1'b0, 1'b0, 8'h00);
      bus.pop = 1'b0;
   endtask

   task automatic read_byte(input int addr, output logic [7:0] d);
      bus.rd_addr = 11'(addr);
      tick();
      d = bus.rd_data;
   endtask

   task automatic pop_head();
      bus.pop = 1'b1;
      tick();
      bus.pop = 1'b0;
   endtask

   initial begin
      logic [7:0] d;

      //           n_pay  er  base   len   err  addr  rd
      vecs[0] = '{   64,  -1, 8'h00,   64, 1'b0,    5, 8'h05};
      vecs[1] = '{   20,  10, 8'h80,   20, 1'b1,   10, 8'h8A};
      vecs[2] = '{    1,  -1, 8'hA5,    1, 1'b0,    0, 8'hA5};
      vecs[3] = '{ 3000,  -1, 8'h00, 2048, 1'b1, 2047, 8'h30};
      vecs[4] = '{ 3000,  -1, 8'h00, 2048, 1'b1,    0, 8'h00};
      vecs[5] = '{ 2048,  -1, 8'h00, 2048, 1'b0, 2047, 8'h30};

      // Reset with rx_dv held high. The FSM must not start until rx_dv falls.
      rst            = 1'b1;
      bus.rx_dv      = 1'b1;
      bus.rx_er      = 1'b0;
      bus.rx_data    = 8'h55;
      bus.rd_addr    = '0;
      bus.pop        = 1'b0;
      bus_np.rx_dv   = 1'b0;
      bus_np.rx_er   = 1'b0;
      bus_np.rx_data = 8'h00;
      bus_np.rd_addr = '0;
      bus_np.pop     = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      check("rst avail",     32'(bus.frame_avail), 32'd0);
      check("rst len",       32'(bus.frame_len),   32'd0);
      check("rst err",       32'(bus.frame_err),   32'd0);
      check("rst busy",      32'(bus.busy),        32'd0);
      check("rst frame_cnt", 32'(bus.frame_cnt),   32'd0);
      check("rst drop_cnt",  32'(bus.drop_cnt),    32'd0);
      check("rst rd_data",   32'(bus.rd_data),     32'd0);
      repeat (3) drive(1'b1, 1'b0, 8'h55);
      check("armed busy", 32'(bus.busy), 32'd0);
      drive(1'b0, 1'b0, 8'h00);

      // Preamble cut short by rx_dv low: back to IDLE and no count changes.
      repeat (3) drive(1'b1, 1'b0, 8'h55);
      check("pre busy", 32'(bus.busy), 32'd1);
      drive(1'b0, 1'b0, 8'h00);
      check("pre abort busy", 32'(bus.busy),     32'd0);
      check("pre abort drop", 32'(bus.drop_cnt), 32'd0);

      // Bad preamble byte -> DROP, counted once.
      drive(1'b1, 1'b0, 8'h55);
      drive(1'b1, 1'b0, 8'h12);
      exp_dc++;
      check("bad pre busy", 32'(bus.busy),     32'd1);
      check("bad pre drop", 32'(bus.drop_cnt), 32'(exp_dc));
      drive(1'b1, 1'b0, 8'h33);
      drive(1'b1, 1'b0, 8'h44);
      drive(1'b0, 1'b0, 8'h00);
      check("bad pre drop2", 32'(bus.drop_cnt),    32'(exp_dc));
      check("bad pre avail", 32'(bus.frame_avail), 32'd0);
      check("bad pre fcnt",  32'(bus.frame_cnt),   32'd0);
      check("bad pre idle",  32'(bus.busy),        32'd0);

      // SFD followed directly by rx_dv low: empty frame, discarded.
      send_frame(0, 8'h00, -1, 1'b0);
      check("empty avail", 32'(bus.frame_avail), 32'd0);
      check("empty fcnt",  32'(bus.frame_cnt),   32'd0);
      check("empty drop",  32'(bus.drop_cnt),    32'(exp_dc));

      // Table: one frame each, read back, pop.
      for (int i = 0; i < 6; i++) begin
         send_frame(vecs[i].n_pay, vecs[i].base, vecs[i].er_idx, 1'b0);
         exp_fc++;
         check($sformatf("v%0d avail", i), 32'(bus.frame_avail), 32'd1);
         check($sformatf("v%0d len", i),   32'(bus.frame_len),   32'(vecs[i].exp_len));
         check($sformatf("v%0d err", i),   32'(bus.frame_err),   32'(vecs[i].exp_err));
         check($sformatf("v%0d fcnt", i),  32'(bus.frame_cnt),   32'(exp_fc));
         read_byte(vecs[i].rd_addr, d);
         check($sformatf("v%0d rd", i),    32'(d),               32'(vecs[i].exp_rd));
         pop_head();
         check($sformatf("v%0d popped", i), 32'(bus.frame_avail), 32'd0);
         check($sformatf("v%0d len0", i),   32'(bus.frame_len),   32'd0);
      end

      // Five frames into four slots: the fifth is dropped. Drain in order.
      for (int k = 1; k <= 5; k++) send_frame(60, 8'(k * 16), -1, 1'b0);
      exp_fc += 4;
      exp_dc++;
      check("ring fcnt", 32'(bus.frame_cnt), 32'(exp_fc));
      check("ring drop", 32'(bus.drop_cnt),  32'(exp_dc));
      check("ring busy", 32'(bus.busy),      32'd0);
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("ring%0d avail", k), 32'(bus.frame_avail), 32'd1);
         check($sformatf("ring%0d len", k),   32'(bus.frame_len),   32'd60);
         read_byte(0, d);
         check($sformatf("ring%0d byte0", k), 32'(d), 32'(k * 16));
         pop_head();
      end
      check("ring drained", 32'(bus.frame_avail), 32'd0);

      // Commit and pop in the same cycle with two frames queued.
      send_frame(10, 8'h40, -1, 1'b0);
      send_frame(11, 8'h50, -1, 1'b0);
      send_frame(12, 8'h60, -1, 1'b1);
      exp_fc += 3;
      check("cp fcnt",  32'(bus.frame_cnt),   32'(exp_fc));
      check("cp avail", 32'(bus.frame_avail), 32'd1);
      check("cp len a", 32'(bus.frame_len),   32'd11);
      read_byte(0, d);
      check("cp byte a", 32'(d), 32'h50);
      pop_head();
      check("cp avail b", 32'(bus.frame_avail), 32'd1);
      check("cp len b",   32'(bus.frame_len),   32'd12);
      read_byte(0, d);
      check("cp byte b", 32'(d), 32'h60);
      pop_head();
      check("cp empty", 32'(bus.frame_avail), 32'd0);

      // Store-everything instance: preamble bytes land in the slot.
      bus_np.rx_dv = 1'b1;
      bus_np.rx_data = 8'h55; tick();
      bus_np.rx_data = 8'h55; tick();
      bus_np.rx_data = 8'hD5; tick();
      bus_np.rx_data = 8'h01; tick();
      bus_np.rx_dv = 1'b0;    tick();
      check("np avail", 32'(bus_np.frame_avail), 32'd1);
      check("np len",   32'(bus_np.frame_len),   32'd4);
      check("np fcnt",  32'(bus_np.frame_cnt),   32'd1);
      bus_np.rd_addr = 11'd0; tick();
      check("np byte0", 32'(bus_np.rd_data), 32'h55);
      bus_np.rd_addr = 11'd2; tick();
      check("np byte2", 32'(bus_np.rd_data), 32'hD5);

      // Reset in the middle of a frame, with a committed frame still queued.
      send_frame(8, 8'h70, -1, 1'b0);
      for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
      drive(1'b1, 1'b0, 8'hD5);
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'(i));
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      check("mid rst avail", 32'(bus.frame_avail), 32'd0);
      check("mid rst fcnt",  32'(bus.frame_cnt),   32'd0);
      check("mid rst drop",  32'(bus.drop_cnt),    32'd0);
      check("mid rst busy",  32'(bus.busy),        32'd0);
      drive(1'b1, 1'b0, 8'h05);
      drive(1'b1, 1'b0, 8'h06);
      check("mid rst armed", 32'(bus.busy), 32'd0);
      drive(1'b0, 1'b0, 8'h00);
      send_frame(8, 8'h90, -1, 1'b0);
      check("post rst avail", 32'(bus.frame_avail), 32'd1);
      check("post rst len",   32'(bus.frame_len),   32'd8);
      check("post rst fcnt",  32'(bus.frame_cnt),   32'd1);
      read_byte(7, d);
      check("post rst byte7", 32'(d), 32'h97);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/gmii_rx_capture.md
GMII_RX_CAPTURE -- requirements
Module: gmii_rx_capture

Interface
REQ-001 Parameter SLOT_AW, default 11: byte-address width of one frame slot; slot size is 2^SLOT_AW bytes.
REQ-002 Parameter SLOTS_LOG2, default 2: number of frame slots is 2^SLOTS_LOG2, organised as a ring.
REQ-003 Parameter STRIP_PRE, default 1: 1 strips preamble/SFD before storing; 0 stores every byte with rx_dv high.
REQ-004 clock  in  1  single clock for all logic; GMII inputs are already in this domain.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 rx_dv  in  1  GMII receive data valid.
REQ-007 rx_er  in  1  GMII receive error.
REQ-008 rx_data  in  8  GMII receive byte.
REQ-009 frame_avail  out  1  head slot holds a committed frame.
REQ-010 frame_len  out  SLOT_AW+1  byte count of the head frame; 0 when frame_avail=0.
REQ-011 frame_err  out  1  head frame saw rx_er or was truncated.
REQ-012 rd_addr  in  SLOT_AW  byte index within the head slot.
REQ-013 rd_data  out  8  head-slot byte at rd_addr, registered.
REQ-014 pop  in  1  one-cycle pulse: release the head slot.
REQ-015 frame_cnt  out  16  committed frames, wraps modulo 2^16.
REQ-016 drop_cnt  out  16  frames dropped, saturates at 0xFFFF.
REQ-017 busy  out  1  receive FSM is not in IDLE.

Function
REQ-018 The receive FSM SHALL have four states: IDLE, PRE, DATA, DROP.
REQ-019 IDLE: rx_dv=1 SHALL go to PRE when STRIP_PRE=1, else to DATA (or DROP when full), with the first byte stored at offset 0.
REQ-020 PRE: byte 0x55 stays in PRE; 0xD5 goes to DATA (or DROP when full); any other byte goes to DROP; rx_dv=0 returns to IDLE with no count change.
REQ-021 "Full" SHALL mean occupancy equals 2^SLOTS_LOG2, evaluated before any same-cycle pop; a drop decision increments drop_cnt once.
REQ-022 DATA: each rx_dv=1 byte SHALL be written to the write slot at offset len, and len increments.
REQ-023 Bytes arriving when len=2^SLOT_AW SHALL NOT be written; len saturates and the slot's truncation flag is set.
REQ-024 rx_er=1 in any cycle of DATA SHALL set the slot's error flag; the frame is still committed.
REQ-025 DATA with rx_dv=0 and len>0 SHALL commit: store len and the error flag, advance the write pointer, increment occupancy and frame_cnt, and go to IDLE; frame_avail is visible from the same clock edge.
REQ-026 DATA with rx_dv=0 and len=0 SHALL discard the frame with no counter change.
REQ-027 DROP SHALL write nothing and return to IDLE when rx_dv=0.
REQ-028 rd_data SHALL equal mem[head slot, rd_addr] one cycle after rd_addr is presented.
REQ-029 pop with frame_avail=1 SHALL advance the head pointer and decrement occupancy; pop with frame_avail=0 SHALL be ignored.
REQ-030 A commit and a pop in the same cycle SHALL both take effect, leaving occupancy unchanged.
REQ-031 Write and head pointers SHALL wrap modulo 2^SLOTS_LOG2.
REQ-032 The write slot SHALL never equal a committed, unpopped slot.

Reset
REQ-033 Reset SHALL set the FSM to IDLE, pointers, occupancy, len, frame_cnt and drop_cnt to 0, and frame_avail, frame_err and busy to 0.
REQ-034 rd_data SHALL reset to 0x00; memory contents are not cleared.
REQ-035 Reset asserted mid-frame SHALL abandon the frame without commit, and counters read 0.
REQ-036 After reset deasserts while rx_dv=1, the FSM SHALL stay in IDLE until rx_dv has been seen 0.

Verification
REQ-037 7x0x55, 0xD5, 64 payload bytes 0x00..0x3F, then dv low -> frame_avail=1, frame_len=64, frame_cnt=1; rd_addr=5 returns rd_data=0x05 next cycle.
REQ-038 Preamble 0x55, 0x12 -> DROP, drop_cnt=1, nothing committed; the next good frame commits normally.
REQ-039 Five 60-byte frames with no pop (4 slots) -> frame_cnt=4, drop_cnt=1; four pops drain frames 1-4 in order, then frame_avail=0.
REQ-040 3000-byte payload with SLOT_AW=11 -> frame_len=2048, frame_err=1, byte 2047 intact.
REQ-041 rx_er pulsed on payload byte 10 of a 20-byte frame -> frame_len=20, frame_err=1.
REQ-042 Commit and pop in the same cycle with occupancy 2 -> occupancy stays 2; STRIP_PRE=0 run stores 0x55 at offset 0.
